// File: rtl/ahb_bram_bridge.sv
// AHB-Lite slave bridging bus transfers onto a single-port, byte-laned BRAM.
// Reads and writes run with zero wait states; a read accepted during a
// write data phase is held for one wait state because the BRAM port is busy.
// Optional build macro: BRAM_BRIDGE_WPROT_EN enables write protection of the
// first RO_WORDS words with a two-cycle ERROR response.
module ahb_bram_bridge #(
    parameter int AW       = 16,
    parameter int RO_WORDS = 0
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    output logic [AW-3:0] BRAM_ADDR,
    output logic [31:0]   BRAM_WDATA,
    output logic [3:0]    BRAM_WREN,
    input  logic [31:0]   BRAM_RDATA
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_RDW  = 3'd3;
`ifdef BRAM_BRIDGE_WPROT_EN
    localparam logic [2:0] ST_ERR1 = 3'd4;
    localparam logic [2:0] ST_ERR2 = 3'd5;
`endif

    logic [2:0]    state_q, state_d;
    logic [AW-3:0] addr_q, addr_d;
    logic [3:0]    strb_q, strb_d;
    logic          accept_s;
    logic          wr_prot_s;
    logic          unused_s;

    // Byte lanes touched by a transfer; misaligned low address bits are ignored.
    function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] r;
        case (size)
            3'd0:    r = 4'b0001 << a;
            3'd1:    r = a[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    assign accept_s = HSEL & HTRANS[1] & HREADY;

`ifdef BRAM_BRIDGE_WPROT_EN
    localparam logic [31:0] RO_LIMIT = 32'(RO_WORDS);
    assign wr_prot_s = HWRITE & ({{(34-AW){1'b0}}, HADDR[AW-1:2]} < RO_LIMIT);
`else
    assign wr_prot_s = 1'b0;
`endif

    // Upper address bits alias the bank; HTRANS[0] (SEQ vs NONSEQ) is irrelevant.
    assign unused_s = ^{HTRANS[0], HADDR[31:AW], (RO_WORDS != 0)};

    // Next-state and address/strobe capture for the transfer pipeline.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        case (state_q)
            ST_RDW: state_d = ST_RD;
`ifdef BRAM_BRIDGE_WPROT_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: begin
                // IDLE, WR, RD and ERR2 can all accept a new address phase
                if (accept_s) begin
                    addr_d = HADDR[AW-1:2];
                    if (HWRITE) begin
                        strb_d  = lane_strobe(HSIZE, HADDR[1:0]);
                        state_d = wr_prot_s ? 3'd4 : ST_WR;
                    end else begin
                        // the BRAM port is busy with the write: park the read for a cycle
                        state_d = (state_q == ST_WR) ? ST_RDW : ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Bus and BRAM outputs decoded from the current state.
    always_comb begin
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        HRDATA     = 32'h0000_0000;
        BRAM_WDATA = 32'h0000_0000;
        BRAM_WREN  = 4'b0000;
        // a read issued from a state with a free BRAM port goes out in its address phase
        BRAM_ADDR  = (accept_s && !HWRITE && (state_q != ST_WR)) ? HADDR[AW-1:2] : addr_q;
        case (state_q)
            ST_WR: begin
                BRAM_WDATA = HWDATA;
                BRAM_WREN  = strb_q;
            end
            ST_RD:  HRDATA    = BRAM_RDATA;
            ST_RDW: HREADYOUT = 1'b0;
`ifdef BRAM_BRIDGE_WPROT_EN
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
`endif
            default: HREADYOUT = 1'b1;
        endcase
    end

    // State and latched address/strobe registers; reset drops any pending write.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= {(AW-2){1'b0}};
            strb_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
        end
    end

endmodule
